// File: rtl/texture_bank_buffer_if.sv
// rtl/texture_bank_buffer_if.sv - upload stream bundle between the texture DMA and texture_bank_buffer
interface texture_bank_buffer_if #(
  parameter int STREAM_WIDTH = 32
);
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [STREAM_WIDTH-1:0] s_axis_tdata;

  modport master (output s_axis_tvalid, output s_axis_tlast, output s_axis_tdata, input s_axis_tready);
  modport slave  (input s_axis_tvalid, input s_axis_tlast, input s_axis_tdata, output s_axis_tready);
endinterface

// File: rtl/texture_bank_buffer.sv
// rtl/texture_bank_buffer.sv - double-buffered texel store, one upload bank and one quad-read bank
module texture_bank_buffer #(
  parameter int PIXEL_WIDTH    = 32,
  parameter int STREAM_WIDTH   = 32,
  parameter int TEX_ADDR_WIDTH = 17
) (
  input  logic                      aclk,
  input  logic                      reset,
  input  logic [3:0]                confPixelFormat,
  input  logic                      readEnable,
  input  logic [TEX_ADDR_WIDTH-1:0] texelAddr00,
  input  logic [TEX_ADDR_WIDTH-1:0] texelAddr01,
  input  logic [TEX_ADDR_WIDTH-1:0] texelAddr10,
  input  logic [TEX_ADDR_WIDTH-1:0] texelAddr11,
  output logic [PIXEL_WIDTH-1:0]    texelOutput00,
  output logic [PIXEL_WIDTH-1:0]    texelOutput01,
  output logic [PIXEL_WIDTH-1:0]    texelOutput10,
  output logic [PIXEL_WIDTH-1:0]    texelOutput11,
  texture_bank_buffer_if.slave      s_axis,
  input  logic                      swap,
  output logic                      swapPending,
  output logic                      writeBankFull,
  output logic                      readBankValid,
  output logic                      activeBank
);
  localparam int TPB   = STREAM_WIDTH / 16;
  localparam int DEPTH = 1 << TEX_ADDR_WIDTH;

  // One RAM copy per read port; index is {bank, texel address}.
  logic [15:0]               r_mem [4][2*DEPTH];
  logic [TEX_ADDR_WIDTH-1:0] r_waddr;
  logic                      r_active;
  logic                      r_full;
  logic                      r_pend;
  logic                      r_valid;
  logic                      r_bank1;
  logic [TEX_ADDR_WIDTH-1:0] r_addr [4];
  logic [15:0]               r_data [4];
  logic [PIXEL_WIDTH-1:0]    r_out  [4];

  logic [TEX_ADDR_WIDTH-1:0] w_addr [4];
  logic                      w_accept;
  logic                      w_do_swap;

  assign w_addr[0] = texelAddr00;
  assign w_addr[1] = texelAddr01;
  assign w_addr[2] = texelAddr10;
  assign w_addr[3] = texelAddr11;

  assign s_axis.s_axis_tready = !r_full && !reset;
  assign w_accept  = s_axis.s_axis_tvalid && s_axis.s_axis_tready;
  assign w_do_swap = r_full && (swap || r_pend);

  assign swapPending   = r_pend;
  assign writeBankFull = r_full;
  assign readBankValid = r_valid;
  assign activeBank    = r_active;
  assign texelOutput00 = r_out[0];
  assign texelOutput01 = r_out[1];
  assign texelOutput10 = r_out[2];
  assign texelOutput11 = r_out[3];

  function automatic logic [31:0] expand(input logic [15:0] t, input logic [3:0] f);
    logic [31:0] r;
    case (f)
      4'd1:    r = {t[15:11], t[15:13], t[10:6], t[10:8], t[5:1], t[5:3], {8{t[0]}}};
      4'd2:    r = {t[15:11], t[15:13], t[10:5], t[10:9], t[4:0], t[4:2], 8'hFF};
      4'd3:    r = {t[14:10], t[14:12], t[9:5], t[9:7], t[4:0], t[4:2], {8{t[15]}}};
      default: r = {t[15:12], t[15:12], t[11:8], t[11:8], t[7:4], t[7:4], t[3:0], t[3:0]};
    endcase
    return r;
  endfunction

  always_ff @(posedge aclk) begin
    if (w_accept) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < TPB; k++) begin
          r_mem[c][{~r_active, r_waddr + TEX_ADDR_WIDTH'(k)}] <= s_axis.s_axis_tdata[16*k +: 16];
        end
      end
    end
  end

  // A pending swap fires once the tlast beat has marked the bank full.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_waddr  <= '0;
      r_active <= 1'b0;
      r_full   <= 1'b0;
      r_pend   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (w_do_swap) begin
      r_active <= ~r_active;
      r_waddr  <= '0;
      r_full   <= 1'b0;
      r_pend   <= 1'b0;
      r_valid  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_waddr <= r_waddr + TEX_ADDR_WIDTH'(TPB);
        if (s_axis.s_axis_tlast) r_full <= 1'b1;
      end
      if (swap && !r_full) r_pend <= 1'b1;
    end
  end

  // Bank is latched with the addresses so in-flight reads ignore a later swap.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_bank1 <= 1'b0;
      for (int p = 0; p < 4; p++) begin
        r_addr[p] <= '0;
        r_data[p] <= '0;
        r_out[p]  <= '0;
      end
    end else if (readEnable) begin
      r_bank1 <= r_active;
      for (int p = 0; p < 4; p++) begin
        r_addr[p] <= w_addr[p];
        r_data[p] <= r_mem[p][{r_bank1, r_addr[p]}];
        r_out[p]  <= expand(r_data[p], confPixelFormat);
      end
    end
  end
endmodule

// File: tb/tb_texture_bank_buffer.sv
// tb/tb_texture_bank_buffer.sv - scoreboard bench for texture_bank_buffer
module tb_texture_bank_buffer;
  typedef struct packed {
    logic            sel;
    logic [15:0]     id;
    logic [3:0][31:0] e;
  } exp_t;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  fmt = 4'd0;
  logic        ren = 1'b1;
  logic [7:0]  addr [4];
  logic        swap_a = 1'b0;
  logic        swap_b = 1'b0;
  logic [31:0] out_a [4];
  logic [31:0] out_b [4];
  logic        pend_a, full_a, valid_a, act_a;
  logic        pend_b, full_b, valid_b, act_b;
  logic        rd_issue = 1'b0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  exp_t        cur;
  logic        have_cur = 1'b0;
  logic [2:0]  vp = 3'd0;
  logic        out_new = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] mon_got;
  logic [127:0] bd;

  always #5 aclk = ~aclk;

  texture_bank_buffer_if #(.STREAM_WIDTH(32))  if_a ();
  texture_bank_buffer_if #(.STREAM_WIDTH(128)) if_b ();

  texture_bank_buffer #(.PIXEL_WIDTH(32), .STREAM_WIDTH(32), .TEX_ADDR_WIDTH(8)) dut_a (
    .aclk(aclk), .reset(reset), .confPixelFormat(fmt), .readEnable(ren),
    .texelAddr00(addr[0]), .texelAddr01(addr[1]), .texelAddr10(addr[2]), .texelAddr11(addr[3]),
    .texelOutput00(out_a[0]), .texelOutput01(out_a[1]), .texelOutput10(out_a[2]), .texelOutput11(out_a[3]),
    .s_axis(if_a), .swap(swap_a), .swapPending(pend_a), .writeBankFull(full_a),
    .readBankValid(valid_a), .activeBank(act_a)
  );

  texture_bank_buffer #(.PIXEL_WIDTH(32), .STREAM_WIDTH(128), .TEX_ADDR_WIDTH(4)) dut_b (
    .aclk(aclk), .reset(reset), .confPixelFormat(fmt), .readEnable(ren),
    .texelAddr00(addr[0][3:0]), .texelAddr01(addr[1][3:0]), .texelAddr10(addr[2][3:0]), .texelAddr11(addr[3][3:0]),
    .texelOutput00(out_b[0]), .texelOutput01(out_b[1]), .texelOutput10(out_b[2]), .texelOutput11(out_b[3]),
    .s_axis(if_b), .swap(swap_b), .swapPending(pend_b), .writeBankFull(full_b),
    .readBankValid(valid_b), .activeBank(act_b)
  );

  // Tracks which output slots hold a queued read: shifts only when the pipeline advances.
  always @(posedge aclk) begin
    if (reset) begin
      vp <= 3'd0; out_new <= 1'b0; stalled <= 1'b0;
    end else begin
      if (ren) vp <= {vp[1:0], rd_issue};
      out_new <= ren && vp[1];
      stalled <= !ren && vp[2];
    end
  end

  always @(negedge aclk) begin
    if (out_new) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_underflow got=output exp=queued_entry");
      end else begin
        cur = q.pop_front();
        have_cur = 1'b1;
      end
    end
    if ((out_new || stalled) && have_cur) begin
      for (int p = 0; p < 4; p++) begin
        mon_got = cur.sel ? out_b[p] : out_a[p];
        total++;
        if (mon_got !== cur.e[p]) begin
          bad++;
          $display("FAIL %s id=%0d port=%0d got=%h exp=%h", out_new ? "read" : "hold", cur.id, p, mon_got, cur.e[p]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic rd(input logic sel, input int id, input logic [7:0] a0, a1, a2, a3,
                    input logic [31:0] e0, e1, e2, e3);
    exp_t x;
    addr[0] = a0; addr[1] = a1; addr[2] = a2; addr[3] = a3;
    rd_issue = 1'b1;
    x.sel = sel; x.id = 16'(id); x.e = {e3, e2, e1, e0};
    q.push_back(x);
    tick(1);
    rd_issue = 1'b0;
  endtask

  task automatic beat(input logic sel, input logic [127:0] d, input logic last);
    if (sel) begin
      if_b.s_axis_tdata = d; if_b.s_axis_tvalid = 1'b1; if_b.s_axis_tlast = last;
      chk("tready_b_before_beat", 32'(if_b.s_axis_tready), 32'd1);
    end else begin
      if_a.s_axis_tdata = d[31:0]; if_a.s_axis_tvalid = 1'b1; if_a.s_axis_tlast = last;
      chk("tready_a_before_beat", 32'(if_a.s_axis_tready), 32'd1);
    end
    tick(1);
    if_a.s_axis_tvalid = 1'b0; if_a.s_axis_tlast = 1'b0;
    if_b.s_axis_tvalid = 1'b0; if_b.s_axis_tlast = 1'b0;
  endtask

  task automatic pulse_swap(input logic sel);
    if (sel) swap_b = 1'b1; else swap_a = 1'b1;
    tick(1);
    swap_a = 1'b0; swap_b = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) addr[p] = 8'd0;
    if_a.s_axis_tvalid = 1'b0; if_a.s_axis_tlast = 1'b0; if_a.s_axis_tdata = '0;
    if_b.s_axis_tvalid = 1'b0; if_b.s_axis_tlast = 1'b0; if_b.s_axis_tdata = '0;

    tick(2);
    chk("tready_in_reset", 32'(if_a.s_axis_tready), 32'd0);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_pend", 32'(pend_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_active", 32'(act_a), 32'd0);
    chk("rst_out", out_a[0], 32'd0);
    reset = 1'b0;
    #1;
    chk("tready_after_reset", 32'(if_a.s_axis_tready), 32'd1);

    // RGBA4444 upload into bank 1, then publish it.
    beat(1'b0, 128'h00F0F00F, 1'b0);
    beat(1'b0, 128'h1234ABCD, 1'b1);
    chk("full_after_tlast", 32'(full_a), 32'd1);
    chk("tready_when_full", 32'(if_a.s_axis_tready), 32'd0);
    pulse_swap(1'b0);
    chk("active_after_swap", 32'(act_a), 32'd1);
    chk("valid_after_swap", 32'(valid_a), 32'd1);
    chk("full_after_swap", 32'(full_a), 32'd0);
    rd(1'b0, 1, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFF0000FF, 32'h0000FF00, 32'hAABBCCDD, 32'h11223344);
    rd(1'b0, 2, 8'd3, 8'd2, 8'd1, 8'd0, 32'h11223344, 32'hAABBCCDD, 32'h0000FF00, 32'hFF0000FF);
    tick(4);

    // Swap requested before tlast waits for the upload to complete.
    pulse_swap(1'b0);
    chk("early_pend", 32'(pend_a), 32'd1);
    chk("early_active_held", 32'(act_a), 32'd1);
    beat(1'b0, 128'h0000F800, 1'b0);
    beat(1'b0, 128'hFFFF0F0F, 1'b1);
    chk("early_full_at_tlast", 32'(full_a), 32'd1);
    chk("early_active_at_tlast", 32'(act_a), 32'd1);
    tick(1);
    chk("early_active_swapped", 32'(act_a), 32'd0);
    chk("early_pend_cleared", 32'(pend_a), 32'd0);
    chk("early_full_cleared", 32'(full_a), 32'd0);

    // Format expansion of texels F800, 0000, 0F0F, FFFF.
    fmt = 4'd0; rd(1'b0, 10, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFF880000, 32'h00000000, 32'h00FF00FF, 32'hFFFFFFFF); tick(3);
    fmt = 4'd1; rd(1'b0, 11, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFF000000, 32'h00000000, 32'h08E739FF, 32'hFFFFFFFF); tick(3);
    fmt = 4'd2; rd(1'b0, 12, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFF0000FF, 32'h000000FF, 32'h08E37BFF, 32'hFFFFFFFF); tick(3);
    fmt = 4'd3; rd(1'b0, 13, 8'd0, 8'd1, 8'd2, 8'd3, 32'hF70000FF, 32'h00000000, 32'h18C67B00, 32'hFFFFFFFF); tick(3);
    fmt = 4'd9; rd(1'b0, 14, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFF880000, 32'h00000000, 32'h00FF00FF, 32'hFFFFFFFF); tick(3);
    fmt = 4'd0;

    // Stall mid-stream: outputs hold, nothing lost or duplicated.
    rd(1'b0, 20, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFF880000, 32'h00000000, 32'h00FF00FF, 32'hFFFFFFFF);
    rd(1'b0, 21, 8'd1, 8'd2, 8'd3, 8'd0, 32'h00000000, 32'h00FF00FF, 32'hFFFFFFFF, 32'hFF880000);
    rd(1'b0, 22, 8'd2, 8'd3, 8'd0, 8'd1, 32'h00FF00FF, 32'hFFFFFFFF, 32'hFF880000, 32'h00000000);
    ren = 1'b0;
    for (int p = 0; p < 4; p++) addr[p] = 8'd2;
    tick(4);
    ren = 1'b1;
    rd(1'b0, 23, 8'd3, 8'd0, 8'd1, 8'd2, 32'hFFFFFFFF, 32'hFF880000, 32'h00000000, 32'h00FF00FF);
    tick(4);

    // Read captured on the swap edge still comes from the old bank.
    beat(1'b0, 128'h5555AAAA, 1'b1);
    swap_a = 1'b1;
    rd(1'b0, 30, 8'd0, 8'd1, 8'd2, 8'd3, 32'hFF880000, 32'h00000000, 32'h00FF00FF, 32'hFFFFFFFF);
    swap_a = 1'b0;
    rd(1'b0, 31, 8'd0, 8'd1, 8'd0, 8'd1, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555);
    chk("inflight_active", 32'(act_a), 32'd1);
    tick(4);

    // Reset after one beat of an upload into bank 0.
    beat(1'b0, 128'h12345678, 1'b0);
    reset = 1'b1;
    #1;
    chk("tready_mid_reset", 32'(if_a.s_axis_tready), 32'd0);
    tick(1);
    reset = 1'b0;
    chk("mid_rst_full", 32'(full_a), 32'd0);
    chk("mid_rst_pend", 32'(pend_a), 32'd0);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_active", 32'(act_a), 32'd0);
    chk("mid_rst_out", out_a[3], 32'd0);
    rd(1'b0, 40, 8'd2, 8'd3, 8'd2, 8'd3, 32'h00FF00FF, 32'hFFFFFFFF, 32'h00FF00FF, 32'hFFFFFFFF);
    tick(3);
    beat(1'b0, 128'h99993333, 1'b1);
    pulse_swap(1'b0);
    chk("post_rst_active", 32'(act_a), 32'd1);
    rd(1'b0, 41, 8'd0, 8'd1, 8'd2, 8'd3, 32'h33333333, 32'h99999999, 32'hAABBCCDD, 32'h11223344);
    tick(4);

    // 128-bit stream into a 16-texel bank: third beat wraps onto texels 0-7.
    for (int k = 0; k < 8; k++) bd[16*k +: 16] = 16'(16'h1111 * k);
    beat(1'b1, bd, 1'b0);
    for (int k = 0; k < 8; k++) bd[16*k +: 16] = 16'(16'h1111 * (k + 8));
    beat(1'b1, bd, 1'b0);
    for (int k = 0; k < 8; k++) bd[16*k +: 16] = 16'hA000 | 16'(k);
    beat(1'b1, bd, 1'b1);
    chk("wrap_full", 32'(full_b), 32'd1);
    pulse_swap(1'b1);
    chk("wrap_active", 32'(act_b), 32'd1);
    chk("wrap_valid", 32'(valid_b), 32'd1);
    rd(1'b1, 50, 8'd0, 8'd3, 8'd8, 8'd15, 32'hAA000000, 32'hAA000033, 32'h88888888, 32'hFFFFFFFF);
    rd(1'b1, 51, 8'd5, 8'd7, 8'd9, 8'd12, 32'hAA000055, 32'hAA000077, 32'h99999999, 32'hCCCCCCCC);
    tick(5);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
